// File: rtl/dtcore32_trap_ctrl.sv
// Machine-mode trap controller beside the WB stage. Accepts a trap or mret
// reaching WB, commits the M-mode trap CSRs, and issues a one-cycle PC redirect
// to the IF PC mux. Also hosts those CSRs for the CSR read/write path.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a trap or mret in WB; CSR writes accepted here
// COMMIT   | write mepc/mcause/mtval/mstatus from the holding registers
// REDIRECT | one-cycle redirect to the trap vector (mtvec)
// MRET     | one-cycle redirect to mepc; restore MIE from MPIE
module dtcore32_trap_ctrl #(
   parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        WB_trap_valid_i,
   input  logic [31:0] WB_trap_pc_i,
   input  logic [31:0] WB_trap_mcause_i,
   input  logic [31:0] WB_trap_mtval_i,
   input  logic        WB_mret_i,
   input  logic        csr_wr_en_i,
   input  logic [11:0] csr_wr_addr_i,
   input  logic [31:0] csr_wr_data_i,
   input  logic [11:0] csr_rd_addr_i,
   output logic [31:0] csr_rd_data_o,
   output logic        trap_busy_o,
   output logic        redirect_valid_o,
   output logic [31:0] redirect_pc_o
);

   localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
   localparam logic [11:0] ADDR_MTVEC    = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
   localparam logic [11:0] ADDR_MEPC     = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
   localparam logic [11:0] ADDR_MTVAL    = 12'h343;
   localparam logic [31:0] ALIGN_MASK    = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COMMIT   = 2'd1,
      REDIRECT = 2'd2,
      MRET     = 2'd3
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] hold_pc;
   logic [31:0] hold_mcause;
   logic [31:0] hold_mtval;
   logic [31:0] mtvec;
   logic [31:0] mepc;
   logic [31:0] mcause;
   logic [31:0] mtval;
   logic [31:0] mscratch;
   logic        mie;
   logic        mpie;
   logic        csr_wr_ok;

   // A trapping instruction must not retire, so its CSR write is dropped.
   assign csr_wr_ok = csr_wr_en_i && (state == IDLE) && !WB_trap_valid_i;

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic; trap outranks mret, both ignored outside IDLE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (WB_trap_valid_i) state_next = COMMIT;
            else if (WB_mret_i)  state_next = MRET;
         end
         COMMIT:   state_next = REDIRECT;
         REDIRECT: state_next = IDLE;
         MRET:     state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   // Outputs decoded straight from state and CSR flops, so they change only on clock edges.
   always_comb begin
      trap_busy_o      = (state != IDLE);
      redirect_valid_o = 1'b0;
      redirect_pc_o    = 32'h0;
      if (state == REDIRECT) begin
         redirect_valid_o = 1'b1;
         redirect_pc_o    = mtvec;
      end else if (state == MRET) begin
         redirect_valid_o = 1'b1;
         redirect_pc_o    = mepc;
      end
   end

   // Capture the trapping instruction's details for the commit cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hold_pc     <= 32'h0;
         hold_mcause <= 32'h0;
         hold_mtval  <= 32'h0;
      end else if (state == IDLE && WB_trap_valid_i) begin
         hold_pc     <= WB_trap_pc_i;
         hold_mcause <= WB_trap_mcause_i;
         hold_mtval  <= WB_trap_mtval_i;
      end
   end

   // Trap CSRs: software writes in IDLE, hardware updates in COMMIT and MRET.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mtvec    <= RESET_MTVEC & ALIGN_MASK;
         mepc     <= 32'h0;
         mcause   <= 32'h0;
         mtval    <= 32'h0;
         mscratch <= 32'h0;
         mie      <= 1'b0;
         mpie     <= 1'b0;
      end else if (state == COMMIT) begin
         mepc   <= hold_pc & ALIGN_MASK;
         mcause <= hold_mcause;
         mtval  <= hold_mtval;
         mpie   <= mie;
         mie    <= 1'b0;
      end else if (state == MRET) begin
         mie  <= mpie;
         mpie <= 1'b1;
      end else if (csr_wr_ok) begin
         case (csr_wr_addr_i)
            ADDR_MSTATUS: begin
               mie  <= csr_wr_data_i[3];
               mpie <= csr_wr_data_i[7];
            end
            ADDR_MTVEC:    mtvec    <= csr_wr_data_i & ALIGN_MASK;
            ADDR_MSCRATCH: mscratch <= csr_wr_data_i;
            ADDR_MEPC:     mepc     <= csr_wr_data_i & ALIGN_MASK;
            ADDR_MCAUSE:   mcause   <= csr_wr_data_i;
            ADDR_MTVAL:    mtval    <= csr_wr_data_i;
            default: ;
         endcase
      end
   end

   // Combinational read mux; MPP is hardwired to machine mode.
   always_comb begin
      csr_rd_data_o = 32'h0;
      case (csr_rd_addr_i)
         ADDR_MSTATUS:  csr_rd_data_o = {19'h0, 2'b11, 3'b000, mpie, 3'b000, mie, 3'b000};
         ADDR_MTVEC:    csr_rd_data_o = mtvec;
         ADDR_MSCRATCH: csr_rd_data_o = mscratch;
         ADDR_MEPC:     csr_rd_data_o = mepc;
         ADDR_MCAUSE:   csr_rd_data_o = mcause;
         ADDR_MTVAL:    csr_rd_data_o = mtval;
         default:       csr_rd_data_o = 32'h0;
      endcase
   end

endmodule

// File: tb/tb_dtcore32_trap_ctrl.sv
// Bench for dtcore32_trap_ctrl: a phase-queue model checked every cycle plus
// directed scenarios with hand-computed literal expectations.
module tb_dtcore32_trap_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        WB_trap_valid_i;
   logic [31:0] WB_trap_pc_i;
   logic [31:0] WB_trap_mcause_i;
   logic [31:0] WB_trap_mtval_i;
   logic        WB_mret_i;
   logic        csr_wr_en_i;
   logic [11:0] csr_wr_addr_i;
   logic [31:0] csr_wr_data_i;
   logic [11:0] csr_rd_addr_i;
   logic [31:0] csr_rd_data_o;
   logic        trap_busy_o;
   logic        redirect_valid_o;
   logic [31:0] redirect_pc_o;

   int n_total = 0;
   int n_pass  = 0;
   int redirect_count = 0;

   dtcore32_trap_ctrl #(.RESET_MTVEC(32'h0000_0103)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .WB_trap_valid_i(WB_trap_valid_i), .WB_trap_pc_i(WB_trap_pc_i),
      .WB_trap_mcause_i(WB_trap_mcause_i), .WB_trap_mtval_i(WB_trap_mtval_i),
      .WB_mret_i(WB_mret_i),
      .csr_wr_en_i(csr_wr_en_i), .csr_wr_addr_i(csr_wr_addr_i),
      .csr_wr_data_i(csr_wr_data_i), .csr_rd_addr_i(csr_rd_addr_i),
      .csr_rd_data_o(csr_rd_data_o), .trap_busy_o(trap_busy_o),
      .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // Pending work after an accepted event is a queue of per-cycle phases.
   typedef enum {PH_COMMIT, PH_REDIR, PH_MRET} ph_t;
   ph_t         ph_q[$];
   logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval, m_mscratch;
   logic        m_mie, m_mpie;
   logic [31:0] c_pc, c_cause, c_tval;

   function automatic logic [31:0] m_read(input logic [11:0] a);
      case (a)
         12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
         12'h305: return m_mtvec;
         12'h340: return m_mscratch;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h343: return m_mtval;
         default: return 32'h0;
      endcase
   endfunction

   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ph_q.delete();
         m_mtvec = 32'h0000_0100;
         m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mscratch = 0;
         m_mie = 0; m_mpie = 0;
      end else if (ph_q.size() != 0) begin
         ph_t ph;
         ph = ph_q.pop_front();
         if (ph == PH_COMMIT) begin
            m_mepc = c_pc & 32'hFFFF_FFFC;
            m_mcause = c_cause;
            m_mtval = c_tval;
            m_mpie = m_mie;
            m_mie = 0;
         end else if (ph == PH_MRET) begin
            m_mie = m_mpie;
            m_mpie = 1;
         end
      end else if (WB_trap_valid_i) begin
         c_pc = WB_trap_pc_i; c_cause = WB_trap_mcause_i; c_tval = WB_trap_mtval_i;
         ph_q.push_back(PH_COMMIT);
         ph_q.push_back(PH_REDIR);
      end else begin
         if (csr_wr_en_i) begin
            case (csr_wr_addr_i)
               12'h300: begin m_mie = csr_wr_data_i[3]; m_mpie = csr_wr_data_i[7]; end
               12'h305: m_mtvec = csr_wr_data_i & 32'hFFFF_FFFC;
               12'h340: m_mscratch = csr_wr_data_i;
               12'h341: m_mepc = csr_wr_data_i & 32'hFFFF_FFFC;
               12'h342: m_mcause = csr_wr_data_i;
               12'h343: m_mtval = csr_wr_data_i;
               default: ;
            endcase
         end
         if (WB_mret_i) ph_q.push_back(PH_MRET);
      end
   end

   // Per-cycle comparison against the model, mid-cycle.
   always @(negedge clk_i) begin
      if (!rst_i) begin
         logic        e_busy, e_rv;
         logic [31:0] e_pc;
         e_busy = (ph_q.size() != 0);
         e_rv   = e_busy && (ph_q[0] != PH_COMMIT);
         e_pc   = !e_rv ? 32'h0 : (ph_q[0] == PH_REDIR ? m_mtvec : m_mepc);
         chk("busy", 32'(trap_busy_o), 32'(e_busy));
         chk("redirect_valid", 32'(redirect_valid_o), 32'(e_rv));
         chk("redirect_pc", redirect_pc_o, e_pc);
         chk("csr_rd_data", csr_rd_data_o, m_read(csr_rd_addr_i));
         if (redirect_valid_o) redirect_count++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk_i);
      #2;
   endtask

   task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
      csr_rd_addr_i = a;
      #1;
      chk(name, csr_rd_data_o, exp);
   endtask

   task automatic trap(input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] tval);
      WB_trap_valid_i = 1; WB_trap_pc_i = pc; WB_trap_mcause_i = cause; WB_trap_mtval_i = tval;
   endtask

   initial begin
      rst_i = 1;
      WB_trap_valid_i = 0; WB_trap_pc_i = 0; WB_trap_mcause_i = 0; WB_trap_mtval_i = 0;
      WB_mret_i = 0; csr_wr_en_i = 0; csr_wr_addr_i = 0; csr_wr_data_i = 0;
      csr_rd_addr_i = 12'h305;
      step(); step();
      rst_i = 0;
      rd("reset_mtvec", 12'h305, 32'h0000_0100);
      chk("reset_busy", 32'(trap_busy_o), 0);
      chk("reset_rv", 32'(redirect_valid_o), 0);
      chk("reset_rpc", redirect_pc_o, 0);
      rd("reset_mstatus", 12'h300, 32'h0000_1800);

      // Configure mtvec and MIE, then take a trap.
      csr_wr_en_i = 1; csr_wr_addr_i = 12'h305; csr_wr_data_i = 32'h8000_0040;
      step();
      csr_wr_addr_i = 12'h300; csr_wr_data_i = 32'h0000_0008;
      step();
      csr_wr_en_i = 0;
      rd("mtvec_wr", 12'h305, 32'h8000_0040);
      rd("mie_set", 12'h300, 32'h0000_1808);
      trap(32'h0000_1236, 32'd2, 32'hDEAD_BEEF);
      step();
      WB_trap_valid_i = 0;
      chk("commit_busy", 32'(trap_busy_o), 1);
      chk("commit_rv", 32'(redirect_valid_o), 0);
      step();
      chk("redir_rv", 32'(redirect_valid_o), 1);
      chk("redir_pc", redirect_pc_o, 32'h8000_0040);
      step();
      chk("post_rv", 32'(redirect_valid_o), 0);
      chk("post_busy", 32'(trap_busy_o), 0);
      rd("trap_mepc", 12'h341, 32'h0000_1234);
      rd("trap_mcause", 12'h342, 32'd2);
      rd("trap_mtval", 12'h343, 32'hDEAD_BEEF);
      rd("trap_mstatus", 12'h300, 32'h0000_1880);

      // mret back to mepc.
      WB_mret_i = 1;
      step();
      WB_mret_i = 0;
      chk("mret_rv", 32'(redirect_valid_o), 1);
      chk("mret_pc", redirect_pc_o, 32'h0000_1234);
      step();
      rd("mret_mstatus", 12'h300, 32'h0000_1888);

      // Trap + mret together, extra trap at N+1, then a trap at N+3.
      redirect_count = 0;
      trap(32'h0000_2000, 32'd3, 32'h0); WB_mret_i = 1;
      step();
      WB_mret_i = 0; trap(32'h0000_3000, 32'd7, 32'h1);
      step();
      WB_trap_valid_i = 0;
      chk("prio_redir_pc", redirect_pc_o, 32'h8000_0040);
      step();
      chk("prio_one_redirect", 32'(redirect_count), 1);
      rd("prio_mcause", 12'h342, 32'd3);
      rd("prio_mepc", 12'h341, 32'h0000_2000);
      trap(32'h0000_5000, 32'd5, 32'h55);
      step();
      WB_trap_valid_i = 0;
      chk("n3_busy", 32'(trap_busy_o), 1);
      step(); step();
      rd("n3_mcause", 12'h342, 32'd5);

      // CSR write concurrent with a trap is dropped; in IDLE it lands.
      csr_rd_addr_i = 12'h340;
      trap(32'h0000_6000, 32'd11, 32'h0);
      csr_wr_en_i = 1; csr_wr_addr_i = 12'h340; csr_wr_data_i = 32'h5A5A_5A5A;
      step();
      WB_trap_valid_i = 0; csr_wr_en_i = 0;
      step(); step();
      rd("mscratch_dropped", 12'h340, 32'h0);
      csr_wr_en_i = 1;
      step();
      csr_wr_en_i = 0;
      rd("mscratch_wr", 12'h340, 32'h5A5A_5A5A);
      csr_wr_en_i = 1; csr_wr_addr_i = 12'h7C0;
      step();
      csr_wr_en_i = 0;
      rd("unimpl_rd", 12'h7C0, 32'h0);

      // Reset during REDIRECT aborts the redirect.
      csr_rd_addr_i = 12'h341;
      trap(32'h0000_7004, 32'd4, 32'h0);
      step();
      WB_trap_valid_i = 0;
      step();
      chk("pre_rst_rv", 32'(redirect_valid_o), 1);
      rst_i = 1;
      #1;
      chk("rst_rv", 32'(redirect_valid_o), 0);
      chk("rst_busy", 32'(trap_busy_o), 0);
      chk("rst_rpc", redirect_pc_o, 0);
      chk("rst_mepc", csr_rd_data_o, 32'h0);
      step();
      rst_i = 0;
      step();
      chk("rst_after_rv", 32'(redirect_valid_o), 0);
      rd("rst_mtvec", 12'h305, 32'h0000_0100);
      step(); step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/dtcore32_trap_ctrl.md
# dtcore32_trap_ctrl

Machine-mode trap controller that consumes the per-stage trap signalling and the pipeline's flush/stall behaviour at its far end. It accepts the trap that reaches WB, commits mepc/mcause/mtval/mstatus, and issues a single-cycle PC redirect to the trap vector. It also services `mret` by redirecting to mepc and hosts the M-mode trap CSRs for the CSR read/write path. The block sits beside the WB stage, and its redirect feeds the IF PC mux.

## Interface
Parameters:
- `RESET_MTVEC`, default 32'h0000_0000: reset value of mtvec; bits [1:0] are ignored and forced to 0.

Ports:
- `clk_i` in 1: the single clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `WB_trap_valid_i` in 1: the instruction in WB carries a trap.
- `WB_trap_pc_i` in 32: PC of the trapping instruction.
- `WB_trap_mcause_i` in 32: cause code.
- `WB_trap_mtval_i` in 32: trap value.
- `WB_mret_i` in 1: the instruction in WB is a valid `mret`.
- `csr_wr_en_i` in 1: CSR write from the WB stage.
- `csr_wr_addr_i` in 12: CSR write address.
- `csr_wr_data_i` in 32: CSR write data.
- `csr_rd_addr_i` in 12: CSR read address.
- `csr_rd_data_o` out 32: combinational read data.
- `trap_busy_o` out 1: registered; high while the FSM is not IDLE.
- `redirect_valid_o` out 1: registered single-cycle PC redirect.
- `redirect_pc_o` out 32: registered redirect target.

## Operation
- CSRs implemented:
  - mstatus 0x300: MIE bit 3, MPIE bit 7, MPP [12:11] reads 2'b11; all other bits read 0.
  - mtvec 0x305: direct mode only; bits [1:0] read 0.
  - mscratch 0x340.
  - mepc 0x341: bits [1:0] read 0.
  - mcause 0x342.
  - mtval 0x343.
  - Any other address reads 0, and writes to it are dropped.
- FSM states:
  - IDLE:
    - `WB_trap_valid_i` captures pc/mcause/mtval into holding registers and moves to COMMIT.
    - Otherwise, `WB_mret_i` moves to MRET.
    - Otherwise, stay in IDLE.
  - COMMIT: update the CSRs from the holding registers:
    - mepc <= {pc[31:2], 2'b00};
    - mcause <= captured mcause;
    - mtval <= captured mtval;
    - MPIE <= MIE;
    - MIE <= 0.
    - Then move to REDIRECT.
  - REDIRECT: `redirect_valid_o` = 1 and `redirect_pc_o` = {mtvec[31:2], 2'b00}; then move to IDLE.
  - MRET: `redirect_valid_o` = 1, `redirect_pc_o` = mepc, MIE <= MPIE, MPIE <= 1; then move to IDLE.
- Priority: trap beats mret when both are high in the same cycle.
- Trap and mret inputs are ignored while the FSM is not IDLE. During that time the pipeline keeps flushing younger stages through its own trap signals.
- CSR writes take effect only when the FSM is IDLE and `WB_trap_valid_i` = 0. A write suppressed by either condition is dropped, not deferred, because the trapping instruction must not retire.
- A CSR write to mstatus in IDLE updates only MIE and MPIE.
- `csr_rd_data_o` always reflects the registered CSR values, so a write becomes visible on the cycle after it is accepted.

## Timing
- Reset (async, immediate):
  - FSM = IDLE.
  - `trap_busy_o`, `redirect_valid_o` = 0; `redirect_pc_o` = 0.
  - mtvec = {RESET_MTVEC[31:2], 2'b00}.
  - mepc, mcause, mtval, mscratch = 0; MIE = MPIE = 0.
- Trap sampled in cycle N:
  - N+1: COMMIT; `trap_busy_o` = 1; CSRs update at the end of N+1.
  - N+2: REDIRECT; `redirect_valid_o` = 1, `trap_busy_o` = 1.
  - N+3: IDLE; all outputs low.
  - Trap-to-redirect latency is 2 cycles.
- mret sampled in cycle N:
  - N+1: MRET; `redirect_valid_o` = 1 with the mepc value held at N+1; `trap_busy_o` = 1.
  - N+2: IDLE.
- `redirect_valid_o` is never high for two consecutive cycles.
- A trap arriving in the same cycle the FSM returns to IDLE (N+3) is accepted normally.
- A CSR write to mtvec accepted in cycle N is used by a trap sampled at N+1 or later.
- Reset asserted mid-sequence (COMMIT, REDIRECT or MRET) aborts it: there is no redirect, and CSR updates not yet clocked are lost.

## Test plan
- Reset with RESET_MTVEC = 32'h0000_0103 -> read 0x305 returns 32'h0000_0100; all outputs 0.
- Write mtvec = 32'h8000_0040, set MIE = 1, then trap with pc = 32'h0000_1236, mcause = 2, mtval = 32'hDEAD_BEEF -> redirect at N+2 to 32'h8000_0040. Afterwards mepc = 32'h0000_1234, mcause = 2, mtval = 32'hDEAD_BEEF, MIE = 0, MPIE = 1.
- mret after the previous case -> redirect at N+1 to 32'h0000_1234, MIE = 1, MPIE = 1.
- Trap and mret high in the same cycle, plus a second trap pulse at N+1 -> exactly one redirect (to mtvec); the N+1 trap is ignored.
- csr_wr_en to mscratch with data 32'h5A5A_5A5A in the same cycle as a trap -> mscratch remains 0. Repeat the write in IDLE -> read returns 32'h5A5A_5A5A the next cycle.
- Assert rst_i during REDIRECT -> `redirect_valid_o` drops immediately, FSM is IDLE, mepc = 0.
